// File: rtl/sig_storage_ring.sv
// rtl/sig_storage_ring.sv - per-channel sample store: handshaked window fill, edge-stepped playback
// Optional feature macro: SIG_STORAGE_PARITY_EN (per-word even parity, sticky parityErr).
module sig_storage_ring #(
   parameter  int DATA_W      = 32,
   parameter  int DEPTH       = 256,
   parameter  int REQ_TIMEOUT = 15,
   localparam int AW          = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              resetN,
   input  logic [AW-1:0]     baseAddr,
   input  logic [AW:0]       numWords,
   input  logic              loopMode,
   input  logic              storeConfig,
   input  logic              fetch,
   input  logic              returnToBaseAddr,
   output logic              request,
   input  logic              bramValid,
   input  logic [DATA_W-1:0] bramData,
   input  logic              incrementAddr,
   output logic [DATA_W-1:0] playbackOut,
   output logic              fillDone,
   output logic              wrapPulse,
   output logic              timeoutErr,
   output logic              parityErr,
   output logic [AW-1:0]     pointerDBG,
   output logic              writeDBG
);
   localparam int TW = $clog2(REQ_TIMEOUT + 1);
   localparam logic [AW:0]   CNT_ONE = 1;
   localparam logic [AW-1:0] PTR_ONE = 1;
   localparam logic [TW-1:0] TO_LAST = TW'(REQ_TIMEOUT - 1);
   localparam logic [TW-1:0] TO_ONE  = 1;

   typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

   state_t            state;
   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     stored_base, wr_ptr, rd_ptr, last_addr;
   logic [AW:0]       stored_words, word_cnt;
   logic              stored_loop, inc_prev, inc_edge, wr_en;
   logic [TW-1:0]     wait_cnt;

   assign wr_en      = resetN && (state == WAIT) && bramValid;
   assign inc_edge   = incrementAddr && !inc_prev;
   assign last_addr  = stored_base + stored_words[AW-1:0] - PTR_ONE;
   assign pointerDBG = rd_ptr;

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= bramData;
   end

   always_ff @(posedge clk) begin
      if (!resetN) begin
         state        <= IDLE;
         stored_base  <= '0;
         stored_words <= '0;
         stored_loop  <= 1'b0;
         wr_ptr       <= '0;
         word_cnt     <= '0;
         wait_cnt     <= '0;
         request      <= 1'b0;
         fillDone     <= 1'b0;
         timeoutErr   <= 1'b0;
         writeDBG     <= 1'b0;
      end else begin
         request  <= 1'b0;
         writeDBG <= wr_en;
         case (state)
            IDLE: begin
               fillDone <= 1'b0;
               if (storeConfig) begin
                  stored_base  <= baseAddr;
                  stored_words <= numWords;
                  stored_loop  <= loopMode;
                  timeoutErr   <= 1'b0;
               end
               if (fetch && stored_words != '0) begin
                  state    <= REQ;
                  request  <= 1'b1;
                  wr_ptr   <= stored_base;
                  word_cnt <= '0;
               end
            end
            REQ: begin
               wait_cnt <= '0;
               state    <= fetch ? WAIT : IDLE;
            end
            WAIT: begin
               // A word arriving alongside fetch dropping is still committed.
               if (bramValid) begin
                  wr_ptr   <= wr_ptr + PTR_ONE;
                  word_cnt <= word_cnt + CNT_ONE;
               end
               if (!fetch) begin
                  state <= IDLE;
               end else if (bramValid) begin
                  if (word_cnt + CNT_ONE == stored_words) begin
                     state    <= DONE;
                     fillDone <= 1'b1;
                  end else begin
                     state   <= REQ;
                     request <= 1'b1;
                  end
               end else if (wait_cnt == TO_LAST) begin
                  timeoutErr <= 1'b1;
                  state      <= IDLE;
               end else begin
                  wait_cnt <= wait_cnt + TO_ONE;
               end
            end
            DONE: begin
               if (!fetch) begin
                  state    <= IDLE;
                  fillDone <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!resetN) begin
         rd_ptr      <= '0;
         inc_prev    <= 1'b0;
         wrapPulse   <= 1'b0;
         playbackOut <= '0;
      end else begin
         inc_prev    <= incrementAddr;
         wrapPulse   <= 1'b0;
         playbackOut <= mem[rd_ptr];
         if (returnToBaseAddr) begin
            rd_ptr <= stored_base;
         end else if (inc_edge) begin
            if (stored_loop && rd_ptr == last_addr) begin
               rd_ptr    <= stored_base;
               wrapPulse <= 1'b1;
            end else begin
               rd_ptr <= rd_ptr + PTR_ONE;
            end
         end
      end
   end

`ifdef SIG_STORAGE_PARITY_EN
   logic             par_mem [DEPTH];
   logic [DEPTH-1:0] written;
   logic             rd_par, rd_written;

   always_ff @(posedge clk) begin
      if (wr_en) par_mem[wr_ptr] <= ^bramData;
   end

   // rd_par/rd_written are registered alongside playbackOut so the check lines up with it.
   always_ff @(posedge clk) begin
      if (!resetN) begin
         written    <= '0;
         rd_par     <= 1'b0;
         rd_written <= 1'b0;
         parityErr  <= 1'b0;
      end else begin
         if (wr_en) written[wr_ptr] <= 1'b1;
         rd_par     <= par_mem[rd_ptr];
         rd_written <= written[rd_ptr];
         if (state == IDLE && storeConfig)
            parityErr <= 1'b0;
         else if (rd_written && ((^playbackOut) != rd_par))
            parityErr <= 1'b1;
      end
   end
`else
   assign parityErr = 1'b0;
`endif

endmodule
